// File: rtl/axi_wr_sched_if.sv
// Write-master link used by axi_wr_sched: burst trigger/address/length out, beat accept and done in.
// The master modport is the scheduler side; the slave modport is the AXI write master side.
interface axi_wr_sched_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_trig;
  logic [7:0]            wr_len;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_data_en;
  logic                  wr_ready;
  logic                  wr_done;

  modport master (
    output wr_trig, wr_len, wr_addr, wr_data,
    input  wr_data_en, wr_ready, wr_done
  );

  modport slave (
    input  wr_trig, wr_len, wr_addr, wr_data,
    output wr_data_en, wr_ready, wr_done
  );
endinterface

// File: rtl/axi_wr_sched.sv
// Round-robin burst scheduler sharing one write master between two streaming channels.
// Request sampled in IDLE -> wr_trig next cycle; one burst in flight, pops follow the master's beat accepts.
module axi_wr_sched #(
  parameter int                    ADDR_WIDTH  = 27,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [7:0]            BURST_LEN   = 8'd8,
  parameter logic [ADDR_WIDTH-1:0] CH0_BASE    = 27'h0000000,
  parameter logic [ADDR_WIDTH-1:0] CH1_BASE    = 27'h0100000,
  parameter logic [ADDR_WIDTH-1:0] REGION_SIZE = 27'h0100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  ch0_req,
  input  logic [DATA_WIDTH-1:0] ch0_data,
  output logic                  ch0_rd_en,
  output logic                  ch0_done,
  input  logic                  ch0_addr_rst,
  input  logic                  ch1_req,
  input  logic [DATA_WIDTH-1:0] ch1_data,
  output logic                  ch1_rd_en,
  output logic                  ch1_done,
  input  logic                  ch1_addr_rst,
  output logic                  grant,
  output logic                  busy,
  axi_wr_sched_if.master        wr_if
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP =
    ADDR_WIDTH'(int'(BURST_LEN) * DATA_WIDTH / 8);
  localparam logic [1:0][ADDR_WIDTH-1:0] BASE = {CH1_BASE, CH0_BASE};

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, UPDATE} state_t;

  state_t                        state_q, state_d;
  logic                          grant_q, grant_d;
  logic                          busy_q, busy_d;
  logic                          trig_q, trig_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [1:0]                    done_q, done_d;
  logic [1:0]                    pend_q, pend_d;
  logic [1:0][ADDR_WIDTH-1:0]    ptr_q, ptr_d;

  logic [1:0]                    req;
  logic [1:0]                    addr_rst;
  logic                          start;
  logic [ADDR_WIDTH-1:0]         nxt_ptr;

  assign req      = {ch1_req, ch0_req};
  assign addr_rst = {ch1_addr_rst, ch0_addr_rst};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    trig_d  = 1'b0;
    addr_d  = addr_q;
    done_d  = '0;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    start   = 1'b0;
    nxt_ptr = '0;

    case (state_q)
      IDLE: begin
        if (init_end && wr_if.wr_ready && (|req)) begin
          start   = 1'b1;
          // Both requesting: hand the path to whoever did not have it last.
          grant_d = (&req) ? ~grant_q : req[1];
          addr_d  = ptr_q[grant_d];
          trig_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = TRIG;
        end
      end
      TRIG: state_d = WAIT;
      WAIT: begin
        if (wr_if.wr_done) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        done_d[grant_q] = 1'b1;
        busy_d          = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset aimed at the channel being written (or just granted) is deferred to UPDATE.
    for (int i = 0; i < 2; i++) begin
      if (addr_rst[i]) begin
        if ((busy_q && grant_q == 1'(i)) || (start && grant_d == 1'(i))) begin
          pend_d[i] = 1'b1;
        end else begin
          ptr_d[i] = BASE[i];
        end
      end
    end

    if (state_q == UPDATE) begin
      nxt_ptr = ptr_q[grant_q] + ADDR_STEP;
      if (pend_q[grant_q] || addr_rst[grant_q]) begin
        ptr_d[grant_q] = BASE[grant_q];
      end else if (nxt_ptr == BASE[grant_q] + REGION_SIZE) begin
        ptr_d[grant_q] = BASE[grant_q];
      end else begin
        ptr_d[grant_q] = nxt_ptr;
      end
      pend_d[grant_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
      addr_q  <= '0;
      done_q  <= '0;
      pend_q  <= '0;
      ptr_q   <= BASE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      trig_q  <= trig_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant          = grant_q;
  assign busy           = busy_q;
  assign ch0_done       = done_q[0];
  assign ch1_done       = done_q[1];
  assign ch0_rd_en      = wr_if.wr_data_en && busy_q && !grant_q;
  assign ch1_rd_en      = wr_if.wr_data_en && busy_q && grant_q;

  assign wr_if.wr_trig  = trig_q;
  assign wr_if.wr_len   = BURST_LEN;
  assign wr_if.wr_addr  = addr_q;
  assign wr_if.wr_data  = grant_q ? ch1_data : ch0_data;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Bench for axi_wr_sched with a 64-byte region so wrap is reachable; a simple write-master
// responder answers bursts and a monitor logs every burst for the scenario tasks to score.
module tb_axi_wr_sched;

  localparam logic [26:0] B0   = 27'h0000000;
  localparam logic [26:0] B1   = 27'h0100000;
  localparam logic [26:0] RSZ  = 27'h40;
  localparam logic [26:0] STEP = 27'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_end;
  logic        ch0_req, ch1_req, ch0_addr_rst, ch1_addr_rst;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_rd_en, ch1_rd_en, ch0_done, ch1_done;
  logic        grant, busy;

  int checks = 0;
  int errors = 0;

  axi_wr_sched_if #(.ADDR_WIDTH(27), .DATA_WIDTH(16)) bus ();

  axi_wr_sched #(.REGION_SIZE(RSZ)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .init_end     (init_end),
    .ch0_req      (ch0_req),
    .ch0_data     (ch0_data),
    .ch0_rd_en    (ch0_rd_en),
    .ch0_done     (ch0_done),
    .ch0_addr_rst (ch0_addr_rst),
    .ch1_req      (ch1_req),
    .ch1_data     (ch1_data),
    .ch1_rd_en    (ch1_rd_en),
    .ch1_done     (ch1_done),
    .ch1_addr_rst (ch1_addr_rst),
    .grant        (grant),
    .busy         (busy),
    .wr_if        (bus.master)
  );

  always #5 clk = ~clk;

  // Burst log filled by the monitor
  logic [26:0] trig_addr_q[$];
  logic        trig_grant_q[$];
  logic        done_ch_q[$];
  int          done_own_q[$];
  int          done_oth_q[$];
  int          pc0, pc1;
  int          data_bad = 0;
  int          len_bad  = 0;

  // Reference model state
  logic [26:0] m_ptr[2];
  logic        m_grant;

  function automatic logic [26:0] base_of(input logic ch);
    return ch ? B1 : B0;
  endfunction

  function automatic logic [26:0] adv(input logic ch, input logic [26:0] p);
    return (p + STEP == base_of(ch) + RSZ) ? base_of(ch) : p + STEP;
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  initial begin
    ch0_data = '0;
    ch1_data = '0;
    forever begin
      @(posedge clk);
      #1;
      ch0_data = 16'($urandom);
      ch1_data = 16'($urandom);
    end
  end

  // Write-master responder: accepts BURST_LEN beats with random stalls, then pulses done.
  initial begin
    int n;
    bus.wr_ready   = 1'b1;
    bus.wr_data_en = 1'b0;
    bus.wr_done    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.wr_trig) begin
        bus.wr_ready = 1'b0;
        n = 0;
        while (n < 8 && !rst) begin
          bus.wr_data_en = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
          if (bus.wr_data_en && !rst) n++;
        end
        bus.wr_data_en = 1'b0;
        if (!rst) begin
          bus.wr_done = 1'b1;
          @(posedge clk);
          #1;
          bus.wr_done = 1'b0;
        end
        bus.wr_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_trig) begin
        trig_addr_q.push_back(bus.wr_addr);
        trig_grant_q.push_back(grant);
        pc0 = 0;
        pc1 = 0;
        if (bus.wr_len !== 8'd8) len_bad++;
      end
      if (ch0_rd_en) pc0++;
      if (ch1_rd_en) pc1++;
      if (busy && bus.wr_data !== (grant ? ch1_data : ch0_data)) data_bad++;
      if (ch0_done || ch1_done) begin
        done_ch_q.push_back(ch1_done);
        done_own_q.push_back(ch1_done ? pc1 : pc0);
        done_oth_q.push_back(ch1_done ? pc0 : pc1);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b1;
    ch0_req      = 1'b0;
    ch1_req      = 1'b0;
    ch0_addr_rst = 1'b0;
    ch1_addr_rst = 1'b0;
    init_end     = 1'b1;
    trig_addr_q.delete();
    trig_grant_q.delete();
    done_ch_q.delete();
    done_own_q.delete();
    done_oth_q.delete();
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    m_ptr[0] = B0;
    m_ptr[1] = B1;
    m_grant  = 1'b1;
  endtask

  // Returns at the negedge of the cycle where the n-th further done pulse is seen.
  task automatic run_bursts(input int n, output bit ok);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 2000) begin
      @(negedge clk);
      cnt += int'(ch0_done) + int'(ch1_done);
      cyc++;
    end
    ok = (cnt >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch0_req = 1'b0; ch1_req = 1'b0; ch0_addr_rst = 1'b0; ch1_addr_rst = 1'b0;
    init_end = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL reset_grant got=%b want=1", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (bus.wr_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%b want=0", bus.wr_trig); end
    checks++; if (bus.wr_addr !== 27'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", bus.wr_addr); end
    checks++; if ({ch1_done, ch0_done} !== 2'b00) begin errors++; $display("FAIL reset_done got=%b want=00", {ch1_done, ch0_done}); end
    checks++; if (bus.wr_len !== 8'd8) begin errors++; $display("FAIL reset_len got=%0d want=8", bus.wr_len); end
  endtask

  task automatic test_single();
    bit ok;
    logic [26:0] exp_addr;
    apply_reset();
    ch0_req = 1'b1;
    run_bursts(5, ok);
    ch0_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=timeout want=5 bursts"); end
    checks++; if (trig_addr_q.size() != 5) begin errors++; $display("FAIL single_count got=%0d want=5", trig_addr_q.size()); end
    for (int k = 0; k < 5 && k < trig_addr_q.size() && k < done_own_q.size(); k++) begin
      exp_addr = m_ptr[0];
      m_ptr[0] = adv(1'b0, m_ptr[0]);
      checks++; if (trig_addr_q[k] !== exp_addr) begin errors++; $display("FAIL single_addr[%0d] got=%h want=%h", k, trig_addr_q[k], exp_addr); end
      checks++; if (trig_grant_q[k] !== 1'b0) begin errors++; $display("FAIL single_grant[%0d] got=%b want=0", k, trig_grant_q[k]); end
      checks++; if (done_ch_q[k] !== 1'b0 || done_own_q[k] != 8 || done_oth_q[k] != 0) begin
        errors++; $display("FAIL single_pops[%0d] got=ch%0d own=%0d oth=%0d want=ch0 own=8 oth=0", k, done_ch_q[k], done_own_q[k], done_oth_q[k]);
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic        g;
    logic [26:0] exp_addr;
    apply_reset();
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    run_bursts(4, ok);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (!ok || trig_addr_q.size() != 4) begin errors++; $display("FAIL contention_count got=%0d want=4", trig_addr_q.size()); end
    for (int k = 0; k < 4 && k < trig_addr_q.size() && k < done_own_q.size(); k++) begin
      g = pick(1'b1, 1'b1, m_grant);
      m_grant = g;
      exp_addr = m_ptr[g];
      m_ptr[g] = adv(g, m_ptr[g]);
      checks++; if (trig_addr_q[k] !== exp_addr || trig_grant_q[k] !== g) begin
        errors++; $display("FAIL contention[%0d] got=%h/g%0d want=%h/g%0d", k, trig_addr_q[k], trig_grant_q[k], exp_addr, g);
      end
      checks++; if (done_own_q[k] != 8 || done_oth_q[k] != 0) begin
        errors++; $display("FAIL contention_pops[%0d] got own=%0d oth=%0d want own=8 oth=0", k, done_own_q[k], done_oth_q[k]);
      end
    end
  endtask

  task automatic test_addr_rst();
    bit ok;
    bit all_ok = 1'b1;
    bit seen = 1'b0;
    logic [26:0] exp_tab[6];
    exp_tab = '{B1, B0, B0 + 27'h10, B0 + 27'h20, B0, B1};
    apply_reset();
    ch1_req = 1'b1;
    run_bursts(1, ok); all_ok &= ok;
    ch1_req = 1'b0;
    ch0_req = 1'b1;
    run_bursts(2, ok); all_ok &= ok;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = bus.wr_trig;
    end
    repeat (2) @(negedge clk);
    ch0_addr_rst = 1'b1;
    ch1_addr_rst = 1'b1;
    @(negedge clk);
    ch0_addr_rst = 1'b0;
    ch1_addr_rst = 1'b0;
    run_bursts(2, ok); all_ok &= ok;
    ch0_req = 1'b0;
    ch1_req = 1'b1;
    run_bursts(1, ok); all_ok &= ok;
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (!all_ok || !seen || trig_addr_q.size() != 6) begin
      errors++; $display("FAIL addr_rst_count got=%0d want=6", trig_addr_q.size());
    end
    for (int k = 0; k < 6 && k < trig_addr_q.size(); k++) begin
      checks++; if (trig_addr_q[k] !== exp_tab[k]) begin
        errors++; $display("FAIL addr_rst_addr[%0d] got=%h want=%h", k, trig_addr_q[k], exp_tab[k]);
      end
    end
  endtask

  task automatic test_gating();
    bit ok;
    bit seen = 1'b0;
    int ntrig = 0;
    apply_reset();
    init_end = 1'b0;
    ch0_req  = 1'b1;
    ch1_req  = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.wr_trig) ntrig++;
    end
    checks++; if (ntrig != 0) begin errors++; $display("FAIL gating_idle got=%0d trigs want=0", ntrig); end
    init_end = 1'b1;
    for (int c = 0; c < 2 && !seen; c++) begin
      @(negedge clk);
      seen = bus.wr_trig;
    end
    checks++; if (!seen) begin errors++; $display("FAIL gating_release got=no trig want=trig within 2 cycles"); end
    checks++; if (grant !== 1'b0 || bus.wr_addr !== B0) begin
      errors++; $display("FAIL gating_grant got=g%0d/%h want=g0/%h", grant, bus.wr_addr, B0);
    end
    init_end = 1'b0;
    run_bursts(1, ok);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (!ok || trig_addr_q.size() != 1) begin
      errors++; $display("FAIL gating_midburst got=%0d bursts want=1", trig_addr_q.size());
    end
    init_end = 1'b1;
  endtask

  task automatic test_rst_mid();
    bit ok;
    bit seen = 1'b0;
    apply_reset();
    ch0_req = 1'b1;
    run_bursts(2, ok);
    ch0_req = 1'b0;
    ch1_req = 1'b1;
    run_bursts(1, ok);
    ch1_req = 1'b0;
    ch0_req = 1'b1;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = bus.wr_trig;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bus.wr_trig !== 1'b0 || grant !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async got=busy%b trig%b g%b want=busy0 trig0 g1", busy, bus.wr_trig, grant);
    end
    checks++; if (ch0_rd_en !== 1'b0 || bus.wr_addr !== 27'h0) begin
      errors++; $display("FAIL rst_mid_out got=rd%b addr=%h want=rd0 addr=0", ch0_rd_en, bus.wr_addr);
    end
    trig_addr_q.delete();
    trig_grant_q.delete();
    done_ch_q.delete();
    done_own_q.delete();
    done_oth_q.delete();
    ch1_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_bursts(2, ok);
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (!ok || trig_addr_q.size() != 2) begin errors++; $display("FAIL rst_mid_count got=%0d want=2", trig_addr_q.size()); end
    if (trig_addr_q.size() >= 2) begin
      checks++; if (trig_addr_q[0] !== B0 || trig_grant_q[0] !== 1'b0) begin
        errors++; $display("FAIL rst_mid_first got=%h/g%0d want=%h/g0", trig_addr_q[0], trig_grant_q[0], B0);
      end
      checks++; if (trig_addr_q[1] !== B1 || trig_grant_q[1] !== 1'b1) begin
        errors++; $display("FAIL rst_mid_second got=%h/g%0d want=%h/g1", trig_addr_q[1], trig_grant_q[1], B1);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit all_ok = 1'b1;
    logic [1:0]  r;
    logic        g, rc;
    bit          do_rst;
    logic [26:0] exp_addr[$];
    logic        exp_g[$];
    apply_reset();
    for (int it = 0; it < 24; it++) begin
      r      = 2'($urandom_range(1, 3));
      do_rst = ($urandom_range(0, 3) == 0);
      rc     = 1'($urandom_range(0, 1));
      g = pick(r[0], r[1], m_grant);
      m_grant = g;
      exp_addr.push_back(m_ptr[g]);
      exp_g.push_back(g);
      if (do_rst && rc == g) begin
        m_ptr[g] = base_of(g);
      end else begin
        if (do_rst) m_ptr[rc] = base_of(rc);
        m_ptr[g] = adv(g, m_ptr[g]);
      end
      ch0_req = r[0];
      ch1_req = r[1];
      if (do_rst) begin
        if (rc) ch1_addr_rst = 1'b1; else ch0_addr_rst = 1'b1;
      end
      @(negedge clk);
      ch0_addr_rst = 1'b0;
      ch1_addr_rst = 1'b0;
      run_bursts(1, ok);
      all_ok &= ok;
    end
    ch0_req = 1'b0;
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (!all_ok || trig_addr_q.size() != 24) begin errors++; $display("FAIL random_count got=%0d want=24", trig_addr_q.size()); end
    for (int k = 0; k < 24 && k < trig_addr_q.size() && k < done_own_q.size(); k++) begin
      checks++; if (trig_addr_q[k] !== exp_addr[k] || trig_grant_q[k] !== exp_g[k]) begin
        errors++; $display("FAIL random[%0d] got=%h/g%0d want=%h/g%0d", k, trig_addr_q[k], trig_grant_q[k], exp_addr[k], exp_g[k]);
      end
      checks++; if (done_ch_q[k] !== exp_g[k] || done_own_q[k] != 8 || done_oth_q[k] != 0) begin
        errors++; $display("FAIL random_pops[%0d] got=ch%0d own=%0d oth=%0d want=ch%0d own=8 oth=0", k, done_ch_q[k], done_own_q[k], done_oth_q[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_datapath();
    checks++; if (data_bad != 0) begin errors++; $display("FAIL datapath_mux got=%0d bad beats want=0", data_bad); end
    checks++; if (len_bad != 0) begin errors++; $display("FAIL datapath_len got=%0d bad lengths want=0", len_bad); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_addr_rst();
    test_gating();
    test_rst_mid();
    test_random();
    test_datapath();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
